// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Compare at WIDTH+1 bits so the bit shifted out of rem is never lost.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, dvs};
    q_bit    = (shifted >= {1'b0, dvs});
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_restoring.sv
// Signed restoring divider: quotient on lo, remainder on hi, one quotient bit per cycle.
module div_restoring
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             init,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output div_state_t       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             sign_q;
  logic             sign_r;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // Two's-complement magnitude; the most negative value maps to itself read as unsigned.
  always_comb begin
    abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .dvd_msb  (dvd[WIDTH-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            busy <= 1'b1;
            if (b == '0) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              dvd      <= abs_a;
              dvs      <= abs_b;
              rem      <= '0;
              sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
              sign_r   <= a[WIDTH-1];
              count    <= CW'(WIDTH);
              div_zero <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          // The dividend register doubles as the quotient register as bits shift in.
          dvd   <= {dvd[WIDTH-2:0], q_bit};
          rem   <= rem_next;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          lo    <= sign_q ? (~dvd + 1'b1) : dvd;
          hi    <= sign_r ? (~rem + 1'b1) : rem;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_restoring.sv
// Randomized and directed checks of div_restoring against a 64-bit arithmetic model.
module tb_div_restoring;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         init;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  div_state_t   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_hi = '0;
  logic [W-1:0]   last_lo = '0;

  div_restoring dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .init      (init),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .hi        (hi),
    .lo        (lo),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Truncating signed division done in 64 bits, so -2^31 / -1 wraps to 0x80000000.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    logic [63:0] q;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = 64'(sx / sy);
    r  = 64'(sx % sy);
    return {r[W-1:0], q[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int pulse_at, input bit pulse_done);
    logic [2*W-1:0] exp;
    logic [2*W-1:0] got_exp;
    bit zero;
    int want;
    bit seen;
    int busy_bad;
    zero     = (y == '0);
    want     = zero ? 1 : W + 2;
    seen     = 1'b0;
    busy_bad = 0;
    exp      = zero ? {last_hi, last_lo} : model(x, y);
    exp_q.push_back(exp);

    @(negedge clk);
    a = x; b = y; init = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= want + 5 && !seen; cyc++) begin
      @(negedge clk);
      init = 1'b0;
      if (cyc == pulse_at) begin
        a = $urandom; b = $urandom | 32'd1; init = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        got_exp = exp_q.pop_front();
        check("done_latency", W'(cyc), W'(want));
        check("busy_in_done", W'(busy), W'(1));
        check("div_zero", W'(div_zero), W'(zero));
        check("lo", lo, got_exp[W-1:0]);
        check("hi", hi, got_exp[2*W-1:W]);
        last_lo = got_exp[W-1:0];
        last_hi = got_exp[2*W-1:W];
        if (pulse_done) begin
          a = $urandom; b = $urandom | 32'd1; init = 1'b1;
        end
      end else if (!busy) begin
        busy_bad++;
      end
    end
    check("done_seen", W'(seen), W'(1));
    check("busy_gap", W'(busy_bad), W'(0));

    @(negedge clk);
    init = 1'b0;
    check("busy_after", W'(busy), W'(0));
    check("done_pulse_width", W'(done), W'(0));
    if (pulse_done) begin
      repeat (3) begin
        @(negedge clk);
        check("init_in_done_ignored", W'(busy), W'(0));
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dones;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    reset = 1'b1; init = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_div_zero", W'(div_zero), W'(0));
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_state", W'(state_dbg), W'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", W'(busy), W'(0));

    run_op(32'd100, 32'd7, 0, 1'b0);
    run_op(-32'sd7, 32'd2, 0, 1'b0);
    run_op(32'd7, -32'sd2, 0, 1'b0);
    run_op(32'd5, 32'd0, 0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(32'h8000_0000, 32'd1, 0, 1'b0);
    run_op(32'd100, 32'd7, 5, 1'b1);

    for (int i = 0; i < 20; i++) begin
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 1) == 1) ry = W'($signed(ry) >>> $urandom_range(8, 28));
      if ($urandom_range(0, 7) == 0) rx = '0;
      if (ry == '0) ry = 32'd3;
      run_op(rx, ry, 0, 1'b0);
    end
    run_op(32'hDEAD_BEEF, 32'd0, 0, 1'b0);

    // Reset in the middle of a division.
    @(negedge clk);
    a = 32'd100; b = 32'd7; init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", W'(busy), W'(0));
    check("mid_rst_done", W'(done), W'(0));
    check("mid_rst_div_zero", W'(div_zero), W'(0));
    check("mid_rst_hi", hi, '0);
    check("mid_rst_lo", lo, '0);
    check("mid_rst_state", W'(state_dbg), W'(IDLE));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_hi = '0;
    last_lo = '0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", W'(dones), W'(0));
    run_op(32'd100, 32'd7, 0, 1'b0);

    check("scoreboard_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
